// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between a CPU port (read/write with
// byte mask) and a read-only video fetch port; video wins unless the CPU starved.
module mem_arbiter #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] VBASE    = 'h200,
  parameter int            MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [3:0]    c_wmask,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_ready,
  output logic [31:0]   c_rdata,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic          v_valid,
  output logic [31:0]   v_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [3:0]    m_wmask,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int            WW    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_CPU_WR, OWN_VID} owner_t;

  state_t        state_q;
  owner_t        owner_q;
  logic [WW-1:0] wait_cnt_q;
  logic          m_en_q;
  logic          m_we_q;
  logic [3:0]    m_wmask_q;
  logic [AW-1:0] m_addr_q;
  logic [31:0]   m_wdata_q;
  logic          c_ready_q;
  logic          v_valid_q;
  logic [31:0]   c_rdata_q;
  logic [31:0]   v_rdata_q;
  logic          cpu_win;
  logic          vid_win;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    cpu_win = 1'b0;
    vid_win = 1'b0;
    if (c_req && (!v_req || wait_cnt_q == MAX_W)) begin
      cpu_win = 1'b1;
    end else if (v_req) begin
      vid_win = 1'b1;
    end
  end

  // NOTE: non-blocking everywhere so each register reads the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_wmask_q  <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      c_ready_q  <= 1'b0;
      v_valid_q  <= 1'b0;
      c_rdata_q  <= '0;
      v_rdata_q  <= '0;
    end else begin
      c_ready_q <= 1'b0;
      v_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_win || !c_req) begin
            wait_cnt_q <= '0;
          end else if (vid_win && wait_cnt_q != MAX_W) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end

          if (cpu_win) begin
            owner_q   <= c_we ? OWN_CPU_WR : OWN_CPU_RD;
            m_en_q    <= 1'b1;
            m_we_q    <= c_we;
            m_wmask_q <= c_we ? c_wmask : 4'b0000;
            m_addr_q  <= c_addr;
            m_wdata_q <= c_wdata;
            state_q   <= ISSUE;
          end else if (vid_win) begin
            owner_q   <= OWN_VID;
            m_en_q    <= 1'b1;
            m_we_q    <= 1'b0;
            m_wmask_q <= 4'b0000;
            m_addr_q  <= VBASE + v_addr;
            state_q   <= ISSUE;
          end else begin
            owner_q <= OWN_NONE;
          end
        end

        ISSUE: begin
          m_en_q    <= 1'b0;
          m_we_q    <= 1'b0;
          m_wmask_q <= 4'b0000;
          state_q   <= DATA;
        end

        DATA: begin
          // RAM data for the ISSUE strobe is on m_rdata during this cycle.
          case (owner_q)
            OWN_CPU_RD: begin
              c_rdata_q <= m_rdata;
              c_ready_q <= 1'b1;
            end
            OWN_CPU_WR: c_ready_q <= 1'b1;
            OWN_VID: begin
              v_rdata_q <= m_rdata;
              v_valid_q <= 1'b1;
            end
            default: ;
          endcase
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_wmask = m_wmask_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign c_ready = c_ready_q;
  assign c_rdata = c_rdata_q;
  assign v_valid = v_valid_q;
  assign v_rdata = v_rdata_q;

endmodule
